// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, and device ACK. It drives the lines only through open-drain enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic          clk_meta_q, clk_meta_d;
  logic          clk_sync_q, clk_sync_d;
  logic          clk_prev_q, clk_prev_d;
  logic          data_meta_q, data_meta_d;
  logic          data_sync_q, data_sync_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          fe;
  logic          timed;

  assign fe = clk_prev_q & ~clk_sync_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    ack_d       = ack_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
    timed       = (state_q == S_SEND) || (state_q == S_WAIT_ACK) || (state_q == S_WAIT_IDLE);

    // Device-clock watchdog: every falling edge restarts the gap measurement.
    if (timed) begin
      cnt_d = fe ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d   = {~^tx_data, tx_data};
          ack_d     = 1'b0;
          cnt_d     = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        clk_oe_d  = 1'b0;
        bit_cnt_d = 4'd0;
        cnt_d     = cnt_q + 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (fe) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_WAIT_ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end
        end
      end
      S_WAIT_ACK: begin
        if (fe) begin
          ack_d   = ~data_sync_q;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A falling edge arriving on the last count wins over the abort.
    if (timed && !fe && !done_d && (cnt_q == TMO_LAST)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      ack_d     = 1'b0;
      err_d     = 1'b1;
      cnt_d     = '0;
      state_d   = S_IDLE;
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 9'd0;
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign err_timeout = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on open-drain lines, frame model built
// from the byte with plain arithmetic, one task per scenario.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done),
    .ack_ok(ack_ok), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_fe_cyc = 0;
  int done_cnt = 0, err_cnt = 0, busy_rise = 0;
  int inh_run = 0, last_inh = 0, req_run = 0, last_req = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err_timeout) err_cnt <= err_cnt + 1;
    if (busy && !busy_prev) busy_rise <= busy_rise + 1;
    busy_prev <= busy;
    if (ps2_clk_oe && !ps2_data_oe) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin last_inh <= inh_run; inh_run <= 0; end
    if (ps2_clk_oe && ps2_data_oe) req_run <= req_run + 1;
    else if (req_run != 0) begin last_req <= req_run; req_run <= 0; end
  end

  // Expected line frame: [0]=start, [8:1]=data LSB first, [9]=odd parity, [10]=stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Device: waits for request-to-send, clocks n_fe periods, samples on each rising edge.
  task automatic device_rx(input int n_fe, input bit give_ack, input int h,
                           output logic [10:0] frame, output bit ok);
    int w;
    frame = '1;
    ok = 1'b0;
    w = 0;
    while (!(ps2_clk_line && !ps2_data_line) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) return;
    frame[0] = ps2_data_line;
    for (int k = 1; k <= n_fe; k++) begin
      if (k == 11 && give_ack) dev_data_low = 1'b1;
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b1;
      last_fe_cyc = cyc;
      repeat (h) @(negedge clk);
      if (k <= 10) frame[k] = ps2_data_line;
      dev_clk_low = 1'b0;
      if (k == 11) dev_data_low = 1'b0;
    end
    ok = 1'b1;
  endtask

  task automatic wait_done(input int budget, input bit drop_valid,
                           output bit seen, output logic ack);
    seen = 1'b0;
    ack = 1'bx;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        ack = ack_ok;
        if (drop_valid) tx_valid = 1'b0;
      end
    end
  endtask

  task automatic do_send(input logic [7:0] b, input bit give_ack, input int h, input bit stray,
                         output logic [10:0] frame, output bit dev_ok,
                         output bit done_seen, output logic ack_seen);
    fork
      device_rx(11, give_ack, h, frame, dev_ok);
      begin
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (stray) begin
          repeat (100) @(negedge clk);
          tx_data = ~b;
          tx_valid = 1'b1;
          @(negedge clk);
          tx_valid = 1'b0;
        end
        wait_done(4000, 1'b0, done_seen, ack_seen);
      end
    join
    $display("xfer tx=%02h frame=%03h done=%0d ack=%0b", b, frame, done_seen, ack_seen);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    n_cmp++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (ack_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ack_ok: got %b want 0", ack_ok); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_send_ed;
    logic [10:0] fr;
    bit ok, seen;
    logic ack;
    int d0;
    d0 = done_cnt;
    do_send(8'hED, 1'b1, 20, 1'b0, fr, ok, seen, ack);
    repeat (5) @(negedge clk);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL ed_device: got %0d want 1", ok); end
    n_cmp++; if (fr !== exp_frame(8'hED)) begin n_fail++; $display("FAIL ed_frame: got %03h want %03h", fr, exp_frame(8'hED)); end
    n_cmp++; if (!seen || ack !== 1'b1) begin n_fail++; $display("FAIL ed_ack: got done=%0d ack=%b want 1/1", seen, ack); end
    n_cmp++; if (last_inh != INH) begin n_fail++; $display("FAIL ed_inhibit_len: got %0d want %0d", last_inh, INH); end
    n_cmp++; if (last_req != 1) begin n_fail++; $display("FAIL ed_req_len: got %0d want 1", last_req); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL ed_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL ed_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic       par [3];
    logic [10:0] fr;
    bit ok, seen;
    logic ack;
    int r0;
    bytes = '{8'hF4, 8'h00, 8'hFF};
    par   = '{1'b0, 1'b1, 1'b1};
    r0 = busy_rise;
    for (int i = 0; i < 3; i++) begin
      do_send(bytes[i], 1'b1, 16, (i == 0), fr, ok, seen, ack);
      n_cmp++; if (fr !== exp_frame(bytes[i])) begin n_fail++; $display("FAIL b2b_frame%0d: got %03h want %03h", i, fr, exp_frame(bytes[i])); end
      n_cmp++; if (fr[9] !== par[i]) begin n_fail++; $display("FAIL b2b_parity%0d: got %b want %b", i, fr[9], par[i]); end
      n_cmp++; if (!seen || ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack%0d: got done=%0d ack=%b want 1/1", i, seen, ack); end
    end
    repeat (50) @(negedge clk);
    n_cmp++; if (busy_rise - r0 != 3) begin n_fail++; $display("FAIL b2b_transfers: got %0d want 3", busy_rise - r0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_nack;
    logic [10:0] fr;
    bit ok, seen;
    logic ack;
    int e0;
    e0 = err_cnt;
    do_send(8'hF4, 1'b0, 18, 1'b0, fr, ok, seen, ack);
    repeat (5) @(negedge clk);
    n_cmp++; if (!seen || ack !== 1'b0) begin n_fail++; $display("FAIL nack_ack: got done=%0d ack=%b want 1/0", seen, ack); end
    n_cmp++; if (err_cnt != e0) begin n_fail++; $display("FAIL nack_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_timeout;
    logic [10:0] fr;
    bit ok, seen;
    int d0, e0, diff;
    d0 = done_cnt;
    e0 = err_cnt;
    diff = -1;
    fork
      device_rx(4, 1'b0, 20, fr, ok);
      begin
        @(negedge clk);
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        seen = 1'b1;
        diff = cyc - last_fe_cyc;
        n_cmp++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL tmo_oe: got %b%b want 00", ps2_clk_oe, ps2_data_oe); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_tx_ready: got %b want 1", tx_ready); end
        n_cmp++; if (ack_ok !== 1'b0) begin n_fail++; $display("FAIL tmo_ack_ok: got %b want 0", ack_ok); end
      end
    end
    $display("timeout tx=3C seen=%0d cycles_after_fe_pin=%0d", seen, diff);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL tmo_seen: got 0 want 1"); end
    n_cmp++; if (diff < TMO || diff > TMO + 6) begin n_fail++; $display("FAIL tmo_delay: got %0d want %0d..%0d", diff, TMO, TMO + 6); end
    repeat (10) @(negedge clk);
    n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL tmo_no_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL tmo_err_pulses: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    logic [10:0] fr;
    bit ok, seen;
    logic ack;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      device_rx(6, 1'b0, 20, fr, ok);
      begin
        @(negedge clk);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    n_cmp++; if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_data_oe: got %b want 1", ps2_data_oe); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe: got %b%b want 00", ps2_clk_oe, ps2_data_oe); end
    n_cmp++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got ready=%b busy=%b want 1/0", tx_ready, busy); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (done_cnt != d0 || err_cnt != e0) begin n_fail++; $display("FAIL rstmid_pulses: got done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0); end
    do_send(8'hED, 1'b1, 20, 1'b0, fr, ok, seen, ack);
    n_cmp++; if (fr !== exp_frame(8'hED)) begin n_fail++; $display("FAIL rstmid_frame: got %03h want %03h", fr, exp_frame(8'hED)); end
    n_cmp++; if (!seen || ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack: got done=%0d ack=%b want 1/1", seen, ack); end
  endtask

  task automatic test_hold_valid;
    logic [10:0] fr;
    bit ok, seen;
    logic ack;
    int r0;
    r0 = busy_rise;
    @(negedge clk);
    tx_data = 8'hAA;
    tx_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fork
        device_rx(11, 1'b1, 14, fr, ok);
        wait_done(4000, (f == 2), seen, ack);
      join
      $display("hold frame%0d tx=AA frame=%03h done=%0d ack=%0b", f, fr, seen, ack);
      n_cmp++; if (fr !== exp_frame(8'hAA)) begin n_fail++; $display("FAIL hold_frame%0d: got %03h want %03h", f, fr, exp_frame(8'hAA)); end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL hold_done%0d: got 0 want 1", f); end
    end
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (busy_rise - r0 != 3) begin n_fail++; $display("FAIL hold_transfers: got %0d want 3", busy_rise - r0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got %b want 0", busy); end
  endtask

  task automatic test_random;
    logic [10:0] fr;
    bit ok, seen, give;
    logic ack;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      give = 1'($urandom_range(0, 1));
      do_send(b, give, $urandom_range(12, 24), 1'b0, fr, ok, seen, ack);
      n_cmp++; if (fr !== exp_frame(b)) begin n_fail++; $display("FAIL rnd_frame%0d: got %03h want %03h", i, fr, exp_frame(b)); end
      n_cmp++; if (!seen || ack !== give) begin n_fail++; $display("FAIL rnd_ack%0d: got done=%0d ack=%b want 1/%b", i, seen, ack, give); end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_send_ed;
    test_back_to_back;
    test_nack;
    test_timeout;
    test_reset_mid;
    test_hold_valid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
